// File: rtl/mult_sched_pkg.sv
// Shared types and widths for the multiplier scheduler.
package mult_sched_pkg;
  localparam int OPW  = 16;
  localparam int RESW = 32;
  localparam int BSW  = 4;

  typedef enum logic [1:0] {IDLE, ISSUE, COLLECT, RESP} state_e;

  // Keeps the low bs*p bits of an operand, saturating at the full operand width.
  function automatic logic [OPW-1:0] op_mask(input logic [BSW-1:0] bs, input int p);
    int nb;
    nb = int'(bs) * p;
    if (nb >= OPW) op_mask = '1;
    else           op_mask = (OPW'(1) << nb) - OPW'(1);
  endfunction
endpackage

// File: rtl/mult_scheduler_if.sv
// Job-issue and product-chunk bus between the scheduler and the shared seq_mult.
interface mult_scheduler_if #(parameter int P = 2);
  import mult_sched_pkg::*;
  logic [OPW-1:0] m_a;
  logic [OPW-1:0] m_b;
  logic [BSW-1:0] m_bitsize;
  logic           m_valid;
  logic           m_ready;
  logic [P-1:0]   m_p;
  logic           m_newout;
  logic           m_ready_out;

  modport master (output m_a, m_b, m_bitsize, m_valid, m_ready_out,
                  input  m_ready, m_p, m_newout);
  modport slave  (input  m_a, m_b, m_bitsize, m_valid, m_ready_out,
                  output m_ready, m_p, m_newout);
endinterface

// File: rtl/mult_rr_arb.sv
// Round-robin pick: first asserted request at or after the pointer, wrapping.
module mult_rr_arb #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] idx_o
);
  logic found;

  always_comb begin
    int c;
    c     = 0;
    found = 1'b0;
    gnt_o = '0;
    idx_o = '0;
    for (int i = 0; i < N; i++) begin
      c = (int'(ptr_i) + i) % N;
      if (!found && req_i[c]) begin
        found    = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = ($clog2(N))'(c);
      end
    end
  end
endmodule

// File: rtl/mult_scheduler.sv
// Arbitrates NREQ requesters onto one sequential multiplier, one job in flight,
// and reassembles the P-bit product chunks into a right-aligned result.
module mult_scheduler
  import mult_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int P    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ-1:0][OPW-1:0]  req_a,
  input  logic [NREQ-1:0][OPW-1:0]  req_b,
  input  logic [NREQ-1:0][BSW-1:0]  req_bitsize,
  mult_scheduler_if.master          m_if,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [RESW-1:0]           rsp_data,
  output logic                      rsp_err,
  output logic                      busy
);
  localparam int IDW    = $clog2(NREQ);
  localparam int KW     = $clog2(2*OPW+1);
  localparam int NCHUNK = RESW / P;

  state_e          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d, id_q, id_d;
  logic [OPW-1:0]  a_q, a_d, b_q, b_d;
  logic [BSW-1:0]  bs_q, bs_d;
  logic [KW-1:0]   k_q, k_d;
  logic [RESW-1:0] data_q, data_d;
  logic            err_q, err_d;

  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gidx;
  logic [BSW-1:0]  gbs;
  logic            legal;

  mult_rr_arb #(.N(NREQ)) u_arb (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gidx)
  );

  assign gbs   = req_bitsize[gidx];
  assign legal = (gbs != '0) && (int'(gbs) <= OPW / P);

  always_comb begin
    state_d          = state_q;
    ptr_d            = ptr_q;
    id_d             = id_q;
    a_d              = a_q;
    b_d              = b_q;
    bs_d             = bs_q;
    k_d              = k_q;
    data_d           = data_q;
    err_d            = err_q;
    req_ready        = '0;
    rsp_valid        = 1'b0;
    m_if.m_valid     = 1'b0;
    m_if.m_ready_out = 1'b0;
    m_if.m_a         = '0;
    m_if.m_b         = '0;
    m_if.m_bitsize   = '0;

    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready = gnt;
          id_d      = gidx;
          bs_d      = gbs;
          a_d       = req_a[gidx] & op_mask(gbs, P);
          b_d       = req_b[gidx] & op_mask(gbs, P);
          k_d       = '0;
          data_d    = '0;
          err_d     = !legal;
          state_d   = legal ? ISSUE : RESP;
        end
      end
      ISSUE: begin
        m_if.m_valid   = 1'b1;
        m_if.m_a       = a_q;
        m_if.m_b       = b_q;
        m_if.m_bitsize = bs_q;
        if (m_if.m_ready) state_d = COLLECT;
      end
      COLLECT: begin
        m_if.m_ready_out = 1'b1;
        if (m_if.m_newout) begin
          for (int j = 0; j < NCHUNK; j++)
            if (k_q == KW'(j)) data_d[j*P +: P] = m_if.m_p;
          k_d = k_q + KW'(1);
          // Last chunk of a 2*bitsize-digit product closes the job.
          if (k_q + KW'(1) == KW'({bs_q, 1'b0})) state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = IDLE;
          ptr_d   = (id_q == IDW'(NREQ-1)) ? '0 : id_q + IDW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      bs_q    <= '0;
      k_q     <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      bs_q    <= bs_d;
      k_q     <= k_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign rsp_id   = id_q;
  assign rsp_data = data_q;
  assign rsp_err  = err_q;
  assign busy     = (state_q != IDLE);
endmodule

// File: doc/mult_scheduler.md
MULT_SCHEDULER -- requirements
Module: mult_scheduler

Interface
REQ-001 Parameter NREQ, default 4, number of requesters (2..8).
REQ-002 Parameter P, default 2, product bits delivered per multiplier chunk (1, 2, 4 or 8).
REQ-003 Port clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Port req_valid / req_ready  in / out  NREQ  per-requester job handshake.
REQ-006 Port req_a, req_b  in  NREQ x 16  per-requester unsigned operands.
REQ-007 Port req_bitsize  in  NREQ x 4  per-requester operand length in P-bit digits.
REQ-008 Port m_a, m_b  out  16  operands to the shared seq_mult.
REQ-009 Port m_bitsize  out  4  digit count to the shared seq_mult.
REQ-010 Port m_valid / m_ready  out / in  1  job-issue handshake to seq_mult.
REQ-011 Port m_p  in  P  product chunk from seq_mult.
REQ-012 Port m_newout  in  1  chunk-valid strobe.
REQ-013 Port m_ready_out  out  1  result-accept to seq_mult.
REQ-014 Port rsp_valid / rsp_ready  out / in  1  response handshake.
REQ-015 Port rsp_id  out  clog2(NREQ)  index of the served requester.
REQ-016 Port rsp_data  out  32  assembled product, right-aligned.
REQ-017 Port rsp_err  out  1  job rejected.
REQ-018 Port busy  out  1  high in any state except IDLE.

Function
REQ-019 FSM states: IDLE, ISSUE, COLLECT, RESP; exactly one job in flight.
REQ-020 IDLE with any req_valid: grant g by round-robin starting at pointer; pulse req_ready[g] for one cycle; latch operands, bitsize and id.
REQ-021 IDLE with no req_valid: stay in IDLE; all req_ready low.
REQ-022 Legal bitsize is 1..16/P; for an illegal value go IDLE->RESP with rsp_err=1 and rsp_data=0; m_valid never asserts.
REQ-023 Legal job: IDLE->ISSUE; operands masked to their low bitsize*P bits before driving m_a/m_b.
REQ-024 ISSUE: hold m_valid=1 with stable m_a/m_b/m_bitsize until m_ready=1; same cycle go to COLLECT.
REQ-025 COLLECT: m_ready_out=1; each m_newout cycle writes m_p into rsp_data[k*P +: P] (k = chunk count, LSB first) and increments k.
REQ-026 The newout that makes k = 2*bitsize moves COLLECT->RESP; m_newout outside COLLECT is ignored.
REQ-027 rsp_data upper bits beyond 2*bitsize*P are zero.
REQ-028 RESP: hold rsp_valid=1 and rsp_id/rsp_data/rsp_err stable until rsp_ready=1; then go to IDLE and set pointer to (g+1) mod NREQ.
REQ-029 No req_ready is asserted outside IDLE; requesters hold req_valid until granted.
REQ-030 Minimum latency for a legal job, grant to rsp_valid: 1 + issue wait + 2*bitsize newout cycles.
REQ-031 A rejected job also advances the pointer.

Reset
REQ-032 On rst_n low: state IDLE, pointer 0, k 0; all outputs low or zero (req_ready, m_valid, m_ready_out, rsp_valid, rsp_err, rsp_data, rsp_id, busy, m_a, m_b, m_bitsize).
REQ-033 Reset mid-job abandons the job silently; no response is issued. seq_mult shares rst_n.

Structure
REQ-034 Package mult_sched_pkg holds the state enum, OPW=16, RESW=32 and BSW=4.
REQ-035 Round-robin selection is one sub-module, mult_rr_arb (request vector plus pointer in; one-hot grant and index out).

Verification
REQ-036 Single job: id1, a=45, b=157, bitsize=4, P=2 -> exactly 8 chunks captured; rsp_id=1, rsp_data=7065, rsp_err=0.
REQ-037 All four req_valid high after reset, each held until granted -> grant order 0,1,2,3; a re-raised req 0 is served fifth.
REQ-038 bitsize=0, then bitsize=9 (P=2) -> rsp_err=1, rsp_data=0, m_valid stays 0 throughout.
REQ-039 rsp_ready held low 10 cycles -> rsp_* stable, all req_ready stay 0, no new m_valid.
REQ-040 rst_n low after 3 chunks in COLLECT -> every output zero next sample; a following 45x157 job returns 7065.
REQ-041 a=0xFF2D, b=0x009D, bitsize=4 -> m_a=0x002D; rsp_data=7065.
